// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed byte stream
// into 32-bit words, writes them to IMEM and releases the core on a good checksum.
module imem_loader #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error,
    output logic [2:0]        state_dbg
);

    // Handshake: a byte is consumed on every rising edge where in_valid && in_ready;
    // the host holds in_data stable while in_valid is high and in_ready is low.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_HI  = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

    state_t      state, state_next;
    logic [7:0]  count_lo;
    logic [15:0] count;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  sum;
    logic        accept;
    logic [15:0] hdr_count;
    logic        last_byte;

    assign accept    = in_valid & in_ready;
    assign hdr_count = {in_data, count_lo};
    assign last_byte = (byte_idx == 2'd3) && (word_cnt == count - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = HDR_HI;
            end
            HDR_HI: begin
                if (accept) begin
                    if ({1'b0, hdr_count} > 17'(DEPTH_WORDS)) state_next = ERR;
                    else if (hdr_count == 16'd0)              state_next = CHECK;
                    else                                      state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept && last_byte) state_next = CHECK;
            end
            CHECK: begin
                if (accept) state_next = (in_data == sum) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (reload) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bytes of a word shift in from the top so the fourth byte lands in [31:24].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_lo  <= '0;
            count     <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            sum       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) count_lo <= in_data;
                end
                HDR_HI: begin
                    if (accept) count <= hdr_count;
                end
                PAYLOAD: begin
                    if (accept) begin
                        sum      <= sum + in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_cnt[ADDR_W-1:0];
                            mem_wdata <= {in_data, word_buf};
                            word_cnt  <= word_cnt + 16'd1;
                        end else begin
                            word_buf <= {in_data, word_buf[23:8]};
                        end
                    end
                end
                DONE, ERR: begin
                    if (reload) begin
                        sum      <= '0;
                        word_cnt <= '0;
                        byte_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) || (state == HDR_HI) ||
                       (state == PAYLOAD) || (state == CHECK);
    assign core_rst  = (state != DONE);
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign state_dbg = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image streams, header faults, stalls,
// reload and mid-load reset, with an expected-write queue.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int W      = ADDR_W + 32;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;
    logic [2:0]        state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   img_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check("write", {24'd0, mem_addr, mem_wdata},
                  {24'd0, (exp_q.size() > 0) ? exp_q.pop_front() : {W{1'b1}}});
        end
    end

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        if (gap > 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        @(negedge clk);
        while (!in_ready && budget < 20) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_img(input int max_gap);
        foreach (img_q[i]) send_byte(img_q[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic load_basic_image();
        img_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        exp_q.push_back({8'd0, 32'h0000_0013});
        exp_q.push_back({8'd1, 32'h0010_0093});
    endtask

    task automatic load_four_words();
        logic [31:0] words [4];
        logic [7:0]  cs;
        words = '{32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_00FF, 32'h1234_5678};
        cs    = 8'd0;
        img_q = '{8'h04, 8'h00};
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                img_q.push_back(words[w][8*k +: 8]);
                cs = cs + words[w][8*k +: 8];
            end
            exp_q.push_back({8'(w), words[w]});
        end
        img_q.push_back(cs);
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"},     done,         1);
        check({tag, "_core_rst"}, core_rst,     0);
        check({tag, "_error"},    error,        0);
        check({tag, "_pending"},  exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_core_rst",  core_rst,  1);
        check("rst_done",      done,      0);
        check("rst_error",     error,     0);
        check("rst_state",     state_dbg, S_IDLE);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-word image, continuous stream
        load_basic_image();
        send_img(0);
        expect_done("basic");
        check("basic_in_ready", in_ready,  0);
        check("basic_hold_addr", mem_addr,  1);
        check("basic_hold_data", mem_wdata, 32'h0010_0093);
        repeat (3) @(posedge clk);
        #1;
        check("done_sticky", done, 1);

        // Reload from DONE
        pulse_reload();
        check("reload_core_rst", core_rst,  1);
        check("reload_done",     done,      0);
        check("reload_in_ready", in_ready,  1);
        check("reload_state",    state_dbg, S_IDLE);

        // Empty image, good and bad checksum
        img_q = '{8'h00, 8'h00, 8'h00};
        send_img(0);
        expect_done("empty");
        pulse_reload();
        img_q = '{8'h00, 8'h00, 8'h01};
        send_img(0);
        check("badcs_error",    error,    1);
        check("badcs_done",     done,     0);
        check("badcs_core_rst", core_rst, 1);
        pulse_reload();

        // Count too large: abort right after the header
        img_q = '{8'h01, 8'h01};
        send_img(0);
        check("toobig_error",    error,     1);
        check("toobig_in_ready", in_ready,  0);
        check("toobig_state",    state_dbg, S_ERR);
        repeat (3) @(posedge clk);
        #1;
        check("toobig_stays", state_dbg, S_ERR);
        pulse_reload();

        // Four words continuous, then the same image with random stalls
        load_four_words();
        send_img(0);
        expect_done("four_cont");
        pulse_reload();
        load_four_words();
        send_img(3);
        expect_done("four_stall");
        pulse_reload();

        // Reload mid-payload has no effect
        img_q = '{8'h01, 8'h00, 8'h11, 8'h22};
        exp_q.push_back({8'd0, 32'h4433_2211});
        send_img(0);
        pulse_reload();
        check("reload_payload_state", state_dbg, S_PAYLOAD);
        check("reload_payload_core",  core_rst,  1);
        img_q = '{8'h33, 8'h44, 8'hAA};
        send_img(0);
        expect_done("reload_payload");
        pulse_reload();

        // Reset after six payload bytes, then a fresh image
        img_q = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        exp_q.push_back({8'd0, 32'hDDCC_BBAA});
        send_img(0);
        check("pre_rst_pending", exp_q.size(), 0);
        rst = 1'b1;
        #1;
        check("midrst_state",     state_dbg, S_IDLE);
        check("midrst_mem_addr",  mem_addr,  0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_core_rst",  core_rst,  1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_no_write", mem_we, 0);
        load_basic_image();
        send_img(2);
        expect_done("after_rst");
        check("after_rst_state", state_dbg, S_DONE);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, word-address width of instruction memory.
REQ-002 SHALL have parameter: DEPTH_WORDS, 256, max loadable words (<= 2^ADDR_W).
REQ-003 SHALL have port: clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  byte-stream valid from host link.
REQ-006 SHALL have port: in_data  input  8  byte-stream payload.
REQ-007 SHALL have port: in_ready  output  1  loader can accept a byte this cycle.
REQ-008 SHALL have port: reload  input  1  one-cycle request to restart loading.
REQ-009 SHALL have port: mem_we  output  1  instruction-memory write strobe, one-cycle pulse.
REQ-010 SHALL have port: mem_addr  output  ADDR_W  word address of write.
REQ-011 SHALL have port: mem_wdata  output  32  instruction word to write.
REQ-012 SHALL have port: core_rst  output  1  holds the processor core in reset while high.
REQ-013 SHALL have port: done  output  1  image loaded and checksum good.
REQ-014 SHALL have port: error  output  1  load aborted (length or checksum fault).

Function
REQ-015 SHALL accept a byte only on a cycle with in_valid & in_ready high.
REQ-016 SHALL parse the stream as: count LSB, count MSB (16-bit word count), count*4 payload bytes, one checksum byte.
REQ-017 SHALL implement states IDLE (expect count LSB), HDR_HI, PAYLOAD, CHECK, DONE, ERR.
REQ-018 SHALL drive in_ready=1 in IDLE, HDR_HI, PAYLOAD, CHECK; 0 in DONE, ERR.
REQ-019 SHALL assemble payload little-endian: first byte of a word -> bits [7:0], fourth -> [31:24].
REQ-020 SHALL pulse mem_we for exactly one cycle, the cycle after the fourth byte of a word is accepted, with mem_addr = word index (first word 0) and mem_wdata = assembled word.
REQ-021 SHALL hold mem_addr/mem_wdata stable outside write pulses (last written values).
REQ-022 SHALL sustain back-to-back byte acceptance (no bubble between words).
REQ-023 SHALL compute checksum as 8-bit modulo-256 sum of payload bytes only.
REQ-024 SHALL transition HDR_HI -> ERR if count > DEPTH_WORDS, HDR_HI -> CHECK if count == 0, else HDR_HI -> PAYLOAD.
REQ-025 SHALL transition PAYLOAD -> CHECK after byte 4*count accepted.
REQ-026 SHALL transition CHECK -> DONE if received byte equals computed sum, else CHECK -> ERR.
REQ-027 SHALL keep core_rst=1 in all states except DONE; core_rst falls in the cycle DONE is entered (one cycle after checksum byte acceptance).
REQ-028 SHALL drive done=1 only in DONE and error=1 only in ERR.
REQ-029 SHALL, on reload in DONE or ERR, go to IDLE next cycle, clear done/error, raise core_rst, clear checksum and word index.
REQ-030 SHALL ignore reload in IDLE, HDR_HI, PAYLOAD, CHECK.
REQ-031 SHALL ignore in_data whenever in_valid is low (stall anywhere without state change).

Reset
REQ-032 SHALL on rst enter IDLE immediately: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, error=0, checksum=0, byte/word counters=0.
REQ-033 SHALL abort any in-progress load on rst; no partial-word write follows reset release.

Verification
REQ-034 SHALL verify: bytes 02 00 13 00 00 00 93 00 10 00 B6 -> writes addr0=0x00000013, addr1=0x00100093, done=1, core_rst=0, error=0.
REQ-035 SHALL verify: bytes 00 00 00 -> no mem_we, DONE entered; same with checksum 01 -> ERR, core_rst stays 1.
REQ-036 SHALL verify: count 0x0101 (257) with DEPTH_WORDS=256 -> ERR after second byte, in_ready=0, no mem_we.
REQ-037 SHALL verify: in_valid toggled randomly during a 4-word load -> identical writes/addresses as continuous stream.
REQ-038 SHALL verify: rst asserted after 6 payload bytes, then full valid image sent -> only the new image's writes, starting at addr 0.
REQ-039 SHALL verify: reload in DONE -> next cycle core_rst=1, done=0, in_ready=1; reload during PAYLOAD -> no effect.
